// File: rtl/pool_sched.sv
// 2x2 max-pooling scheduler with per-channel line buffers and a show-ahead output FIFO.
// Optional sticky overflow flag enabled by defining POOL_SCHED_OVF_EN.
module pool_sched #(
  parameter int unsigned CH    = 3,
  parameter int unsigned COLS  = 6,
  parameter int unsigned ROWS  = 24,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned RW   = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1,
  localparam int unsigned HCW  = (COLS / 2 > 1) ? $clog2(COLS / 2) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cnn_out,
  input  logic [7:0]     cnn_data_out,
  output logic           cnn_hold,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic [1:0]     out_ch,
  output logic [RW-1:0]  out_row,
  output logic [HCW-1:0] out_col,
  output logic           busy,
  output logic           frame_done,
  output logic           ovf_err
);

  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned EW  = 8 + 2 + RW + HCW;

  localparam logic [CHW-1:0] CH_LAST  = CHW'(CH - 1);
  localparam logic [HCW-1:0] HC_LAST  = HCW'(COLS / 2 - 1);
  localparam logic [RW-1:0]  HR_LAST  = RW'(ROWS / 2 - 1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    HOLD_CNT = (AW + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state_q;
  logic [CHW-1:0] ch_q;
  logic           col_odd_q;
  logic [HCW-1:0] hc_q;
  logic           row_odd_q;
  logic [RW-1:0]  hr_q;
  logic [7:0]     hreg_q [CH];
  logic [7:0]     lbuf_q [CH][COLS/2];

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic [AW:0]    count_d;

  logic           beat;
  logic           is_last;
  logic           push;
  logic           pop;
  logic           full;
  logic           wr_en;
  logic [7:0]     h_cur;
  logic [7:0]     lb_cur;
  logic [7:0]     pair_max;
  logic [7:0]     win_max;
  logic [EW-1:0]  push_word;

  assign beat     = (state_q == RUN) && cnn_out;
  assign h_cur    = hreg_q[ch_q];
  assign lb_cur   = lbuf_q[ch_q][hc_q];
  assign pair_max = (h_cur >= cnn_data_out) ? h_cur : cnn_data_out;
  assign win_max  = (pair_max >= lb_cur) ? pair_max : lb_cur;
  assign is_last  = beat && (ch_q == CH_LAST) && col_odd_q && (hc_q == HC_LAST)
                    && row_odd_q && (hr_q == HR_LAST);
  assign push     = beat && col_odd_q && row_odd_q;
  assign push_word = {win_max, 2'(ch_q), hr_q, hc_q};

  assign full     = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign pop      = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en    = push && (!full || pop);

  assign {out_data, out_ch, out_row, out_col} = mem_q[rd_ptr_q];
  assign cnn_hold   = (count_q >= HOLD_CNT) || (state_q != RUN);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      col_odd_q <= 1'b0;
      hc_q      <= '0;
      row_odd_q <= 1'b0;
      hr_q      <= '0;
      for (int i = 0; i < int'(CH); i++) begin
        hreg_q[i] <= '0;
        for (int j = 0; j < int'(COLS / 2); j++) lbuf_q[i][j] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            ch_q      <= '0;
            col_odd_q <= 1'b0;
            hc_q      <= '0;
            row_odd_q <= 1'b0;
            hr_q      <= '0;
          end
        end
        RUN: begin
          if (beat) begin
            if (!col_odd_q) hreg_q[ch_q] <= cnn_data_out;
            else if (!row_odd_q) lbuf_q[ch_q][hc_q] <= pair_max;
            // Channel carries into column parity/pair, which carries into row.
            if (ch_q == CH_LAST) begin
              ch_q      <= '0;
              col_odd_q <= ~col_odd_q;
              if (col_odd_q) begin
                if (hc_q == HC_LAST) begin
                  hc_q      <= '0;
                  row_odd_q <= ~row_odd_q;
                  if (row_odd_q) hr_q <= hr_q + 1'b1;
                end else begin
                  hc_q <= hc_q + 1'b1;
                end
              end
            end else begin
              ch_q <= ch_q + 1'b1;
            end
            if (is_last) state_q <= DRAIN;
          end
        end
        DRAIN: if (count_q == '0) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

`ifdef POOL_SCHED_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      ovf_q <= 1'b0;
    end else if (push && full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_pool_sched.sv
// Directed bench for pool_sched: a default-size instance for full frames and
// a CH=1, COLS=2, ROWS=2 instance for the single-window case.
module tb_pool_sched;

  localparam int NCH   = 3;
  localparam int NCOLS = 6;
  localparam int NROWS = 24;
  localparam int NBEAT = NCH * NCOLS * NROWS;
  localparam int NPOOL = NBEAT / 4;
`ifdef POOL_SCHED_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic [3:0] row;
    logic [1:0] col;
  } entry_t;

  logic       clk;
  logic       rst;
  logic       start, cnn_out, cnn_hold, out_valid, out_ready, busy, frame_done, ovf_err;
  logic [7:0] cnn_data, out_data;
  logic [1:0] out_ch;
  logic [3:0] out_row;
  logic [1:0] out_col;

  logic       s_start, s_cnn_out, s_hold, s_valid, s_ready, s_busy, s_done, s_ovf;
  logic [7:0] s_data, s_data_o;
  logic [1:0] s_ch;
  logic [0:0] s_row, s_col;

  int checks = 0;
  int errors = 0;

  entry_t got_q[$];
  int     done_cnt, stalls, first_hold;
  bit     timed_out;

  pool_sched #(.CH(NCH), .COLS(NCOLS), .ROWS(NROWS), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cnn_out(cnn_out), .cnn_data_out(cnn_data),
    .cnn_hold(cnn_hold), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col), .busy(busy),
    .frame_done(frame_done), .ovf_err(ovf_err)
  );

  pool_sched #(.CH(1), .COLS(2), .ROWS(2), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .cnn_out(s_cnn_out), .cnn_data_out(s_data),
    .cnn_hold(s_hold), .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data_o),
    .out_ch(s_ch), .out_row(s_row), .out_col(s_col), .busy(s_busy),
    .frame_done(s_done), .ovf_err(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat value for position idx of the channel-interleaved, row-major stream.
  function automatic logic [7:0] bval(input int seed, input int idx);
    int v;
    v = idx * 89 + seed * 31 + (idx % 7) * 41;
    return 8'(v % 256);
  endfunction

  // Expected k-th pooled entry: straight 2x2 maximum over the stream.
  function automatic entry_t exp_entry(input int seed, input int k);
    entry_t     e;
    int         ch, pc, pr, idx;
    logic [7:0] m, v;
    ch = k % NCH;
    pc = (k / NCH) % (NCOLS / 2);
    pr = k / (NCH * NCOLS / 2);
    m  = 8'd0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        idx = ((2 * pr + dr) * NCOLS + (2 * pc + dc)) * NCH + ch;
        v   = bval(seed, idx);
        if (v > m) m = v;
      end
    end
    e.d = m; e.ch = 2'(ch); e.row = 4'(pr); e.col = 2'(pc);
    return e;
  endfunction

  // Core/sink model: issues beats [first,last) honouring cnn_hold unless told
  // otherwise, collects every popped entry, and counts frame_done pulses.
  task automatic drive(input int seed, input int first, input int last, input bit do_start,
                       input bit ignore_hold, input int ready_off, input bit wait_done);
    int idx, cyc;
    bit fin;
    idx = first; cyc = 0; fin = 0;
    stalls = 0; first_hold = -1; timed_out = 0; done_cnt = 0;
    if (do_start) begin
      start = 1'b1; cnn_out = 1'b0;
      @(negedge clk);
      start = 1'b0;
    end
    while (!fin) begin
      if (cyc >= 3000) begin
        timed_out = 1; fin = 1;
      end else if (!wait_done && idx >= last) begin
        fin = 1;
      end else begin
        out_ready = (cyc >= ready_off);
        if (frame_done) done_cnt++;
        if (out_valid && out_ready) got_q.push_back({out_data, out_ch, out_row, out_col});
        if (cnn_hold && first_hold < 0 && idx < last) first_hold = idx;
        if (wait_done && frame_done) begin
          fin = 1;
        end else if (idx < last && (ignore_hold || !cnn_hold)) begin
          cnn_out = 1'b1; cnn_data = bval(seed, idx); idx++;
        end else begin
          cnn_out = 1'b0;
          if (idx < last) stalls++;
        end
      end
      if (fin) begin
        cnn_out = 1'b0;
        if (!wait_done) out_ready = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cnn_hold !== 1'b1) begin errors++; $display("FAIL reset_cnn_hold: got %b expected 1", cnn_hold); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err: got %b expected 0", ovf_err); end
    checks++; if ({out_data, out_ch, out_row, out_col} !== 16'h0) begin errors++; $display("FAIL reset_out_fields: got %h expected 0000", {out_data, out_ch, out_row, out_col}); end
    checks++; if (s_hold !== 1'b1 || s_busy !== 1'b0) begin errors++; $display("FAIL reset_small: got hold=%b busy=%b expected hold=1 busy=0", s_hold, s_busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_beats;
    for (int i = 0; i < 5; i++) begin
      cnn_out = 1'b1; cnn_data = 8'(200 + i);
      @(negedge clk);
    end
    cnn_out = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_entry: got out_valid=%b expected 0", out_valid); end
    checks++; if (busy !== 1'b0 || cnn_hold !== 1'b1) begin errors++; $display("FAIL idle_state: got busy=%b hold=%b expected busy=0 hold=1", busy, cnn_hold); end
  endtask

  task automatic test_single_window;
    logic [7:0] vec [4];
    vec = '{8'd3, 8'd9, 8'd7, 8'd5};
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    checks++; if (s_hold !== 1'b0 || s_busy !== 1'b1) begin errors++; $display("FAIL single_run_entry: got hold=%b busy=%b expected hold=0 busy=1", s_hold, s_busy); end
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_cnn_out = 1'b1; s_data = vec[i];
      @(negedge clk);
      if (i < 3) begin
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: beat %0d got %b expected 0", i, s_valid); end
      end
    end
    s_cnn_out = 1'b0;
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", s_valid); end
    checks++; if (s_data_o !== 8'd9) begin errors++; $display("FAIL single_data: got %0d expected 9", s_data_o); end
    checks++; if (s_ch !== 2'd0 || s_row !== 1'b0 || s_col !== 1'b0) begin errors++; $display("FAIL single_tags: got ch=%0d row=%0d col=%0d expected 0/0/0", s_ch, s_row, s_col); end
    @(negedge clk);
    checks++; if (s_valid !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL single_after_pop: got valid=%b done=%b expected 0/0", s_valid, s_done); end
    @(negedge clk);
    checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL single_done_pulse: got %b expected 1", s_done); end
    @(negedge clk);
    checks++; if (s_done !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got done=%b busy=%b expected 0/0", s_done, s_busy); end
    s_ready = 1'b0;
  endtask

  task automatic test_full_frame;
    entry_t e;
    got_q.delete();
    drive(1, 0, NBEAT, 1'b1, 1'b0, 0, 1'b1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL full_timeout: got %b expected 0", timed_out); end
    checks++; if (got_q.size() != NPOOL) begin errors++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), NPOOL); end
    for (int j = 0; j < got_q.size() && j < NPOOL; j++) begin
      e = exp_entry(1, j);
      checks++; if (got_q[j] !== e) begin errors++; $display("FAIL full_entry[%0d]: got %h expected %h", j, got_q[j], e); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL back_to_back_stalls: got %0d expected 0", stalls); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL full_idle: got busy=%b done=%b expected 0/0", busy, frame_done); end
  endtask

  task automatic test_backpressure;
    entry_t e;
    got_q.delete();
    drive(2, 0, NBEAT, 1'b1, 1'b0, 60, 1'b1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
    checks++; if (first_hold != 24) begin errors++; $display("FAIL bp_hold_point: got beat %0d expected 24", first_hold); end
    checks++; if (got_q.size() != NPOOL) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), NPOOL); end
    for (int j = 0; j < got_q.size() && j < NPOOL; j++) begin
      e = exp_entry(2, j);
      checks++; if (got_q[j] !== e) begin errors++; $display("FAIL bp_entry[%0d]: got %h expected %h", j, got_q[j], e); end
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    entry_t e;
    int     k;
    got_q.delete();
    drive(3, 0, 30, 1'b1, 1'b1, 100000, 1'b0);
    e = exp_entry(3, 0);
    checks++; if (out_valid !== 1'b1 || {out_data, out_ch, out_row, out_col} !== e) begin errors++; $display("FAIL ovf_head: got v=%b %h expected v=1 %h", out_valid, {out_data, out_ch, out_row, out_col}, e); end
    checks++; if (ovf_err !== EXP_OVF) begin errors++; $display("FAIL ovf_flag: got %b expected %b", ovf_err, EXP_OVF); end
    got_q.delete();
    drive(3, 30, NBEAT, 1'b0, 1'b0, 0, 1'b1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL ovf_timeout: got %b expected 0", timed_out); end
    checks++; if (got_q.size() != NPOOL - 2) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), NPOOL - 2); end
    for (int j = 0; j < got_q.size() && j < NPOOL - 2; j++) begin
      k = (j < 4) ? j : j + 2;
      e = exp_entry(3, k);
      checks++; if (got_q[j] !== e) begin errors++; $display("FAIL ovf_entry[%0d]: got %h expected %h", j, got_q[j], e); end
    end
    @(negedge clk);
    checks++; if (ovf_err !== EXP_OVF) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", ovf_err, EXP_OVF); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (ovf_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_clear_on_start: got ovf=%b busy=%b expected 0/1", ovf_err, busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    entry_t e;
    drive(4, 0, 40, 1'b1, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || cnn_hold !== 1'b1) begin errors++; $display("FAIL midrst_state: got valid=%b busy=%b hold=%b expected 0/0/1", out_valid, busy, cnn_hold); end
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    drive(4, 0, NBEAT, 1'b1, 1'b0, 0, 1'b1);
    checks++; if (got_q.size() != NPOOL || done_cnt != 1) begin errors++; $display("FAIL midrst_count: got %0d entries %0d done expected %0d/1", got_q.size(), done_cnt, NPOOL); end
    for (int j = 0; j < got_q.size() && j < NPOOL; j++) begin
      e = exp_entry(4, j);
      checks++; if (got_q[j] !== e) begin errors++; $display("FAIL midrst_entry[%0d]: got %h expected %h", j, got_q[j], e); end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cnn_out = 1'b0; cnn_data = 8'd0; out_ready = 1'b0;
    s_start = 1'b0; s_cnn_out = 1'b0; s_data = 8'd0; s_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_idle_beats;
    test_single_window;
    test_full_frame;
    test_backpressure;
    test_overflow;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
